// File: rtl/unibus_mem_slave.sv
// Unibus slave memory: decodes a 2^AW-word window and answers DATI/DATIP/DATO/DATOB
// cycles through the MSYN/SSYN interlock, with address deskew and array access delays.
module unibus_mem_slave #(
  parameter logic [17:0] BASE   = 18'o000000,
  parameter int          AW     = 12,
  parameter int          DESKEW = 2,
  parameter int          ACCESS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_init,
  input  logic [17:0] bus_addr,
  input  logic [1:0]  bus_c,
  input  logic        bus_msyn,
  input  logic [15:0] bus_d,
  output logic [15:0] bus_d_out,
  output logic        bus_ssyn,
  output logic        sel,
  output logic        rmw_lock
);

  localparam int CW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DESKEW_ST = 2'd1,
    ACCESS_ST = 2'd2,
    SSYN   = 2'd3
  } state_e;

  // Handshake: the master holds bus_msyn high with a stable address/command; the slave
  // raises bus_ssyn once data is committed and holds it until bus_msyn falls, then
  // drops bus_ssyn and bus_d_out one clock later.

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW:0]    addr_q, addr_d;
  logic [1:0]     c_q, c_d;
  logic           ssyn_q, ssyn_d;
  logic [15:0]    dout_q, dout_d;
  logic           lock_q, lock_d;
  logic           commit;
  logic           hit;
  logic [15:0]    rdata;
  logic           we_lo, we_hi;

  logic [15:0] mem [2**AW];

  assign hit   = (bus_addr[17:AW+1] == BASE[17:AW+1]);
  assign sel   = bus_msyn & hit;
  assign rdata = mem[addr_q[AW:1]];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    c_d     = c_q;
    ssyn_d  = ssyn_q;
    dout_d  = dout_q;
    lock_d  = lock_q;
    commit  = 1'b0;
    if (bus_init) begin
      state_d = IDLE;
      cnt_d   = '0;
      ssyn_d  = 1'b0;
      dout_d  = '0;
      lock_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus_msyn && hit) begin
            addr_d  = bus_addr[AW:0];
            c_d     = bus_c;
            cnt_d   = CW'(DESKEW - 1);
            state_d = DESKEW_ST;
          end
        end
        DESKEW_ST: begin
          if (!bus_msyn) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            cnt_d   = CW'(ACCESS - 1);
            state_d = ACCESS_ST;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ACCESS_ST: begin
          if (!bus_msyn) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            // Commit edge: writes land in the array, reads are captured for the bus.
            commit  = 1'b1;
            state_d = SSYN;
            ssyn_d  = 1'b1;
            if (!c_q[1]) dout_d = rdata;
            if (c_q == 2'b01) lock_d = 1'b1;
            if (c_q[1]) lock_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        SSYN: begin
          if (!bus_msyn) begin
            state_d = IDLE;
            ssyn_d  = 1'b0;
            dout_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // DATOB picks a byte lane from address bit 0; DATO writes both lanes.
  assign we_lo = commit & c_q[1] & (~c_q[0] | ~addr_q[0]);
  assign we_hi = commit & c_q[1] & (~c_q[0] |  addr_q[0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      c_q     <= '0;
      ssyn_q  <= 1'b0;
      dout_q  <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      c_q     <= c_d;
      ssyn_q  <= ssyn_d;
      dout_q  <= dout_d;
      lock_q  <= lock_d;
    end
  end

  // The array survives reset and INIT.
  always_ff @(posedge clk) begin
    if (we_lo) mem[addr_q[AW:1]][7:0]  <= bus_d[7:0];
    if (we_hi) mem[addr_q[AW:1]][15:8] <= bus_d[15:8];
  end

  assign bus_ssyn  = ssyn_q;
  assign bus_d_out = dout_q;
  assign rmw_lock  = lock_q;

endmodule
